// File: rtl/led_bar_pkg.sv
// Shared types for the LED bar-graph controller: FSM state encoding and level-width helper.
package led_bar_pkg;

    typedef enum logic [2:0] {
        S_EMPTY     = 3'd0,
        S_PARTIAL   = 3'd1,
        S_FULL      = 3'd2,
        S_AUTO_UP   = 3'd3,
        S_AUTO_DOWN = 3'd4
    } state_t;

    // Bits needed to hold a lit count of 0..width inclusive.
    function automatic int lvl_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/led_bar_therm.sv
// Level-to-thermometer decoder, MSB lit first: therm[WIDTH-1-k] set for k < level.
// Purely combinational, zero latency; no flow control.
module led_bar_therm
    import led_bar_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [lvl_w(WIDTH)-1:0] level,
    output logic [WIDTH-1:0]        therm
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign therm[i] = (int'(level) > (WIDTH - 1 - i));
    end

endmodule

// File: rtl/led_bar_ctrl.sv
// LED bar-graph controller: manual fill/drain or auto bounce, state advances only on tick; outputs registered, 1 cycle after tick.
// Pulses are buffered in pending flags until the next tick (never dropped); LED_BAR_WRAP_EN enables wrap at the manual boundaries.
module led_bar_ctrl
    import led_bar_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    fill_pls,
    input  logic                    drain_pls,
    input  logic                    auto_mode,
    output logic [WIDTH-1:0]        led,
    output logic [lvl_w(WIDTH)-1:0] level,
    output logic                    full,
    output logic                    empty
);

    localparam int LW = lvl_w(WIDTH);
    localparam int AW = LW + 1;
    localparam logic [AW-1:0] MAX_A  = AW'(WIDTH);
    localparam logic [AW-1:0] STEP_A = AW'(STEP);
    localparam logic [LW-1:0] MAX_L  = LW'(WIDTH);

    state_t          state;
    state_t          nxt_state;
    logic            pend_fill;
    logic            pend_drain;
    logic            req_fill;
    logic            req_drain;
    logic [AW-1:0]   lvl_a;
    logic [AW-1:0]   sum_a;
    logic [LW-1:0]   up_sat;
    logic [LW-1:0]   dn_sat;
    logic [LW-1:0]   fill_lvl;
    logic [LW-1:0]   drain_lvl;
    logic [LW-1:0]   nxt_level;
    logic [WIDTH-1:0] nxt_led;

    function automatic state_t manual_state(input logic [LW-1:0] l);
        if (l == '0)
            return S_EMPTY;
        else if (l == MAX_L)
            return S_FULL;
        else
            return S_PARTIAL;
    endfunction

    // A pulse landing on the tick cycle joins that tick's decision.
    assign req_fill  = pend_fill | fill_pls;
    assign req_drain = pend_drain | drain_pls;

    // One extra bit so level + STEP cannot wrap before the saturation compare.
    assign lvl_a  = {1'b0, level};
    assign sum_a  = lvl_a + STEP_A;
    assign up_sat = (sum_a > MAX_A) ? MAX_L : sum_a[LW-1:0];
    assign dn_sat = (lvl_a < STEP_A) ? '0 : LW'(lvl_a - STEP_A);

`ifdef LED_BAR_WRAP_EN
    assign fill_lvl  = (level == MAX_L) ? '0 : up_sat;
    assign drain_lvl = (level == '0) ? MAX_L : dn_sat;
`else
    assign fill_lvl  = up_sat;
    assign drain_lvl = dn_sat;
`endif

    always_comb begin
        nxt_level = level;
        nxt_state = state;
        if (tick) begin
            if (auto_mode) begin
                case (state)
                    S_AUTO_UP: begin
                        if (level == MAX_L)
                            nxt_state = S_AUTO_DOWN;
                        else
                            nxt_level = up_sat;
                    end
                    S_AUTO_DOWN: begin
                        if (level == '0)
                            nxt_state = S_AUTO_UP;
                        else
                            nxt_level = dn_sat;
                    end
                    default: begin
                        if (level == MAX_L) begin
                            nxt_state = S_AUTO_DOWN;
                            nxt_level = dn_sat;
                        end else begin
                            nxt_state = S_AUTO_UP;
                            nxt_level = up_sat;
                        end
                    end
                endcase
            end else if (state == S_AUTO_UP || state == S_AUTO_DOWN) begin
                nxt_state = manual_state(level);
            end else begin
                if (req_fill && !req_drain)
                    nxt_level = fill_lvl;
                else if (req_drain && !req_fill)
                    nxt_level = drain_lvl;
                nxt_state = manual_state(nxt_level);
            end
        end
    end

    led_bar_therm #(
        .WIDTH (WIDTH)
    ) u_therm (
        .level (nxt_level),
        .therm (nxt_led)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_EMPTY;
            level      <= '0;
            led        <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            pend_fill  <= 1'b0;
            pend_drain <= 1'b0;
        end else begin
            pend_fill  <= tick ? 1'b0 : req_fill;
            pend_drain <= tick ? 1'b0 : req_drain;
            state      <= nxt_state;
            level      <= nxt_level;
            led        <= nxt_led;
            full       <= (nxt_level == MAX_L);
            empty      <= (nxt_level == '0);
        end
    end

endmodule

// File: doc/led_bar_ctrl.md
Name: led_bar_ctrl

Overview:
Parametrised LED bar-graph controller, successor to the fixed 16-LED fill/drain practice controller.
- Keeps a fill level 0..WIDTH and drives a thermometer pattern lit from the MSB downward.
- Manual mode: fill/drain pulses change the level by STEP. Auto mode: the bar bounces full/empty on its own.
- Sits after the board's debounce/one-pulse front end; advances only on a divided-rate tick enable, so the whole block runs on the board clock.

Parameters:
WIDTH, 16, number of LEDs (2..64)
STEP, 1, LEDs added/removed per accepted event (1..WIDTH)

Ports:
clk  in  1  system clock; all state updates on posedge clk
rst  in  1  asynchronous, active-high reset
tick  in  1  single-cycle update enable (from clock divider)
fill_pls  in  1  single-cycle fill request (one-pulsed button)
drain_pls  in  1  single-cycle drain request (one-pulsed button)
auto_mode  in  1  0 = manual, 1 = auto bounce (level-sensitive)
led  out  WIDTH  bar pattern; led[WIDTH-1-k] lit for k < level
level  out  $clog2(WIDTH+1)  current lit count
full  out  1  level == WIDTH
empty  out  1  level == 0

Behaviour:
Interface:
- One clock, clk. Reset rst is asynchronous and active-high.
- On rst: level = 0, led = all 0, empty = 1, full = 0, state = S_EMPTY, both pending flags = 0, auto direction = up.

Pending flags (buffering):
- fill_pls / drain_pls set pend_fill / pend_drain on any cycle.
- Flags are consumed and cleared only on a cycle with tick = 1.
- A pulse arriving in the same cycle as the consuming tick is included in that tick's decision.

Manual decision (auto_mode = 0, on tick):
- pend_fill only: level = min(level + STEP, WIDTH).
- pend_drain only: level = max(level - STEP, 0).
- Both pending: cancel; level unchanged; both cleared.
- Neither: no change.
- Arithmetic uses a width of $clog2(WIDTH+1)+1 internally so the sum cannot overflow before the saturation compare.

State machine (registered, derived from the next level):
- S_EMPTY (level == 0), S_PARTIAL, S_FULL (level == WIDTH): manual states.
- S_AUTO_UP, S_AUTO_DOWN: auto states.

Auto behaviour:
- auto_mode rising (sampled on tick): enter S_AUTO_UP, or S_AUTO_DOWN if level == WIDTH.
- Each tick: AUTO_UP adds STEP (saturating); AUTO_DOWN subtracts STEP (saturating).
- Direction reverses on the tick after reaching WIDTH or 0, so the end value is held exactly one tick.
- In auto, pending flags are cleared on every tick and ignored.
- auto_mode falling (on tick): return to the manual state matching the current level; the level is kept.

Outputs and latency:
- led, level, full and empty are registered and update on the clk edge where tick = 1. Latency from tick to output = 1 cycle.
- led is a pure function of registered level: level == WIDTH gives all ones; level == 0 gives all zeros.

Reset mid-operation: rst asserted at any time forces the reset values immediately, independent of clk. Pending pulses are lost.

Optional Feature:
Macro LED_BAR_WRAP_EN.
- Defined: in manual mode, a fill accepted while full sets level = 0 (wrap), and a drain accepted while empty sets level = WIDTH. A partial step past a boundary saturates first; wrapping applies only when already at the boundary. Auto mode is unaffected.
- Undefined: saturating behaviour as above. No extra ports either way.

Decomposition:
- Package led_bar_pkg: state enum (S_EMPTY, S_PARTIAL, S_FULL, S_AUTO_UP, S_AUTO_DOWN), LVL_W function/constant helper.
- Sub-module led_bar_therm: combinational level-to-thermometer (MSB-first) decoder, parameter WIDTH. Its output is registered in led_bar_ctrl.

Test Plan:
- WIDTH=16, STEP=1: rst, then 3 fill_pls each followed by a tick -> level=3, led=16'hE000, empty=0.
- WIDTH=16, STEP=5: 4 fills with ticks -> level 5, 10, 15, 16 (saturates), full=1, led=16'hFFFF; a further fill -> unchanged.
- fill_pls and drain_pls both pending before one tick at level=8 -> level stays 8, both flags cleared; next tick with no pulses -> still 8.
- fill_pls 2 cycles before tick with tick low in between -> applied exactly once on the tick; a second pulse in the tick cycle -> still a single step.
- WIDTH=8, STEP=3, auto_mode=1 from level 0, 8 ticks -> level sequence 3, 6, 8, 8, 5, 2, 0, 0, then 3; pulses ignored.
- rst asserted asynchronously mid-auto at level 6 -> led=0, level=0, empty=1 before the next clk edge. With LED_BAR_WRAP_EN: fill at full -> level 0; drain at empty -> level WIDTH.
